// File: rtl/div_seq.sv
// div_seq: sequencer between CPU control and the 32-bit restoring divider.
// Optional build macro DIV_SEQ_SMALL_BYPASS_EN: skip the divider when |rs| < |rt|.
module div_seq #(
  parameter int unsigned LATENCY = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic        abort,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_init,
  output logic        div_stop,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done,
  output logic        div0_exc
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWait, StFix, StDone, StZero
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            sign_quo_q;
  logic            sign_rem_q;

  logic            neg_a;
  logic            neg_b;
  logic [31:0]     ma;
  logic [31:0]     mb;

  assign neg_a = is_signed & rs[31];
  assign neg_b = is_signed & rt[31];
  // Two's-complement negate; -0x80000000 stays 0x80000000 as an unsigned magnitude.
  assign ma    = neg_a ? (32'd0 - rs) : rs;
  assign mb    = neg_b ? (32'd0 - rt) : rt;

`ifdef DIV_SEQ_SMALL_BYPASS_EN
  logic        bypass_q;
  logic [31:0] rs_q;
  logic        small;
  assign small = (ma < mb);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      div_init   <= 1'b0;
      div_stop   <= 1'b0;
      hi_out     <= '0;
      lo_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0_exc   <= 1'b0;
`ifdef DIV_SEQ_SMALL_BYPASS_EN
      bypass_q   <= 1'b0;
      rs_q       <= '0;
`endif
    end else begin
      div_init <= 1'b0;
      div_stop <= 1'b0;
      done     <= 1'b0;
      div0_exc <= 1'b0;
      // Abort wins over everything, including the FIX capture.
      if (state_q != StIdle && abort) begin
        state_q  <= StIdle;
        div_stop <= 1'b1;
        busy     <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              sign_quo_q <= is_signed & (rs[31] ^ rt[31]);
              sign_rem_q <= neg_a;
              div_a      <= ma;
              div_b      <= mb;
              busy       <= 1'b1;
`ifdef DIV_SEQ_SMALL_BYPASS_EN
              rs_q       <= rs;
`endif
              if (rt == 32'd0) begin
                state_q  <= StZero;
                done     <= 1'b1;
                div0_exc <= 1'b1;
              end else begin
`ifdef DIV_SEQ_SMALL_BYPASS_EN
                bypass_q <= small;
                state_q  <= small ? StFix : StLaunch;
                div_init <= ~small;
`else
                state_q  <= StLaunch;
                div_init <= 1'b1;
`endif
              end
            end else begin
              if (hi_we) hi_out <= wdata;
              if (lo_we) lo_out <= wdata;
            end
          end
          StLaunch: begin
            cnt_q   <= CntW'(LATENCY - 1);
            state_q <= StWait;
          end
          StWait: begin
            if (cnt_q == '0) begin
              state_q <= StFix;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StFix: begin
`ifdef DIV_SEQ_SMALL_BYPASS_EN
            if (bypass_q) begin
              lo_out <= '0;
              hi_out <= rs_q;
            end else begin
              lo_out <= sign_quo_q ? (32'd0 - div_lo) : div_lo;
              hi_out <= sign_rem_q ? (32'd0 - div_hi) : div_hi;
            end
`else
            lo_out <= sign_quo_q ? (32'd0 - div_lo) : div_lo;
            hi_out <= sign_rem_q ? (32'd0 - div_hi) : div_hi;
`endif
            state_q <= StDone;
            done    <= 1'b1;
          end
          StDone, StZero: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
          default: begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: vector table, random ops against a plain-arithmetic model, and abort/reset sequences.
module tb_div_seq;

  localparam int unsigned LATENCY = 34;

  logic        clk, rst, start, is_signed, abort, hi_we, lo_we;
  logic [31:0] rs, rt, wdata, div_a, div_b, div_hi, div_lo, hi_out, lo_out;
  logic        div_init, div_stop, busy, done, div0_exc;

  int tests = 0;
  int fails = 0;
  int init_cnt = 0;
  int stop_cnt = 0;
  int done_cnt = 0;
  logic [31:0] m_hi, m_lo;

  div_seq #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .rs(rs), .rt(rt),
    .abort(abort), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .div_a(div_a), .div_b(div_b), .div_init(div_init), .div_stop(div_stop),
    .div_hi(div_hi), .div_lo(div_lo), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div0_exc(div0_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Divider model: junk until LATENCY cycles after init, then unsigned quotient/remainder.
  int          dcnt;
  logic [31:0] da, db;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= 0; da <= '0; db <= '0; div_hi <= '0; div_lo <= '0;
    end else if (div_stop) begin
      dcnt <= 0;
    end else if (div_init) begin
      da <= div_a; db <= div_b; dcnt <= LATENCY - 1;
      div_hi <= 32'hDEADBEEF; div_lo <= 32'hDEADBEEF;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        div_lo <= da / db;
        div_hi <= da % db;
      end
    end
  end

  always @(negedge clk) begin
    if (div_init) init_cnt <= init_cnt + 1;
    if (div_stop) stop_cnt <= stop_cnt + 1;
    if (done)     done_cnt <= done_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
    longint v;
    v = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    if (v < 0) v = -v;
    return v[31:0];
  endfunction

  // Returns {hi, lo}: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int exp_cycles(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
`ifdef DIV_SEQ_SMALL_BYPASS_EN
    if (mag(sgn, a) < mag(sgn, b)) return 2;
`endif
    return LATENCY + 3;
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, "_hi"}, hi_out, 32'd0);
    check({nm, "_lo"}, lo_out, 32'd0);
    check({nm, "_div_a"}, div_a, 32'd0);
    check({nm, "_div_b"}, div_b, 32'd0);
    check({nm, "_flags"}, {27'd0, div_init, div_stop, busy, done, div0_exc}, 32'd0);
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    hi_we = h; lo_we = l; wdata = d;
    @(posedge clk);
    #1 hi_we = 1'b0; lo_we = 1'b0;
    if (h) m_hi = d;
    if (l) m_lo = d;
  endtask

  task automatic run_op(input string nm, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                        input logic wr);
    int   ecyc, cyc, base;
    logic got, launch;
    ecyc   = exp_cycles(sgn, a, b);
    launch = (ecyc == int'(LATENCY + 3));
    @(negedge clk);
    is_signed = sgn; rs = a; rt = b; start = 1'b1;
    hi_we = wr; lo_we = wr; wdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    base = init_cnt;
    is_signed = 1'($urandom); rs = $urandom; rt = $urandom;
    cyc = 0; got = 1'b0;
    while (!got && cyc < int'(LATENCY + 20)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && launch) begin
        check({nm, "_div_a"}, div_a, mag(sgn, a));
        check({nm, "_div_b"}, div_b, mag(sgn, b));
        check({nm, "_init"}, 32'(div_init), 32'd1);
      end
      if (done) got = 1'b1;
    end
    check({nm, "_done_cycle"}, 32'(cyc), 32'(ecyc));
    check({nm, "_lo"}, lo_out, elo);
    check({nm, "_hi"}, hi_out, ehi);
    check({nm, "_div0"}, 32'(div0_exc), 32'(b == 32'd0));
    @(posedge clk);
    #1;
    check({nm, "_init_pulses"}, 32'(init_cnt - base), launch ? 32'd1 : 32'd0);
    check({nm, "_busy_after"}, {30'd0, busy, done}, 32'd0);
    m_hi = ehi; m_lo = elo;
  endtask

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, lo, hi;
    string       nm;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int bi, bs, bd;
    logic [63:0] r;
    logic sgn;
    logic [31:0] a, b;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,        32'd2,        "divu_100_7"};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD,  32'hFFFFFFFF, "div_m7_2"};
    vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000,  32'd0,        "div_ovf"};
    vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF,  32'd0,        "divu_max_1"};
    vecs[4] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD,  32'd1,        "div_7_m2"};
    vecs[5] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD, 32'd2,         32'hFFFFFFFE, "div_m8_m3"};
    vecs[6] = '{1'b0, 32'd3,          32'd9,        32'd0,         32'd3,        "divu_3_9"};
    vecs[7] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 32'd0,         32'h80000000, "divu_big"};
    vecs[8] = '{1'b1, 32'hFFFFFFF9,   32'h80000000, 32'd0,         32'hFFFFFFF9, "div_m7_min"};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; rs = '0; rt = '0;
    abort = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    mt(1'b1, 1'b1, 32'h5A5A5A5A);
    check("mt_both_hi", hi_out, 32'h5A5A5A5A);
    check("mt_both_lo", lo_out, 32'h5A5A5A5A);
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    check("mthi", hi_out, 32'h11);
    check("mtlo", lo_out, 32'h22);

    run_op("div0", 1'b0, 32'd5, 32'd0, 32'h22, 32'h11, 1'b0);
    run_op("div0_wr", 1'b1, 32'hFFFFFFF0, 32'd0, 32'h22, 32'h11, 1'b1);

    // Abort in IDLE must do nothing.
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("idle_abort_stop", {30'd0, div_stop, busy}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].nm, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, 1'b0);
    end

    for (int i = 0; i < 30; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 16));
        2:       b = 32'd0 - 32'($urandom_range(1, 16));
        3:       b = 32'd0;
        default: b = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : 32'h80000000;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h80000000;
      r = (b == 32'd0) ? {m_hi, m_lo} : ref_div(sgn, a, b);
      run_op($sformatf("rand%0d", i), sgn, a, b, r[31:0], r[63:32], 1'($urandom));
    end

    // Abort in WAIT; a start and an MT write issued while busy must be ignored.
    mt(1'b1, 1'b0, 32'h1111);
    mt(1'b0, 1'b1, 32'h2222);
    @(negedge clk);
    is_signed = 1'b0; rs = 32'd1000; rt = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; bi = init_cnt; bs = stop_cnt; bd = done_cnt;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 4) begin
        start = 1'b1; rs = 32'd77; rt = 32'd0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hBAD;
      end
      if (c == 5) begin start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; end
      if (c == 11) begin
        check("abort_busy_before", 32'(busy), 32'd1);
        abort = 1'b1;
      end
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_stop_pulse", 32'(div_stop), 32'd1);
    check("abort_busy_low", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    check("abort_stop_once", 32'(div_stop), 32'd0);
    repeat (45) @(negedge clk);
    @(posedge clk);
    #1;
    check("abort_inits", 32'(init_cnt - bi), 32'd1);
    check("abort_stops", 32'(stop_cnt - bs), 32'd1);
    check("abort_no_done", 32'(done_cnt - bd), 32'd0);
    check("abort_hi", hi_out, 32'h1111);
    check("abort_lo", lo_out, 32'h2222);
    check("abort_div_a_held", div_a, 32'd1000);

    // Asynchronous reset mid-WAIT, between clock edges.
    @(negedge clk);
    is_signed = 1'b0; rs = 32'd1000; rt = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    run_op("post_rst", 1'b0, 32'd50, 32'd7, 32'd7, 32'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequencer between the CPU control FSM and the 32-bit restoring divider.
- Upstream side: latches rs/rt for DIV/DIVU, converts signed operands to magnitudes, detects divide-by-zero, pulses the divider's init, and waits the divider's fixed latency.
- Downstream side: captures the divider's unsigned hi/lo, applies sign correction, and writes the architectural HI/LO registers.
- Also serves MTHI/MTLO writes and gives control a busy/done handshake.

Parameters:
- LATENCY, 34: cycles from the div_init pulse until div_hi/div_lo are valid and stable.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset rst, asynchronous, active-high
- start  in  1  one-cycle command, sampled only in IDLE
- is_signed  in  1  1=DIV, 0=DIVU, sampled with start
- rs  in  32  dividend, sampled with start
- rt  in  32  divisor, sampled with start
- abort  in  1  cancel the operation in flight
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wdata  in  32  MTHI/MTLO data
- div_a  out  32  dividend magnitude to divider, held stable LAUNCH..FIX
- div_b  out  32  divisor magnitude to divider, held stable LAUNCH..FIX
- div_init  out  1  one-cycle start pulse to divider
- div_stop  out  1  one-cycle cancel pulse to divider
- div_hi  in  32  unsigned remainder from divider
- div_lo  in  32  unsigned quotient from divider
- hi_out  out  32  architectural HI
- lo_out  out  32  architectural LO
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- div0_exc  out  1  one-cycle divide-by-zero pulse, coincident with done

Behaviour:
- Reset (async): state=IDLE, counter=0, all internal latches=0. Every output resets to 0: hi_out, lo_out, div_a, div_b, div_init, div_stop, busy, done, div0_exc.
- Operand latch on start in IDLE:
  - Latch sign_q = is_signed & (rs[31]^rt[31]) and sign_r = is_signed & rs[31].
  - Magnitudes: ma = (is_signed & rs[31]) ? -rs : rs; mb likewise for rt. Both are 32-bit unsigned, so -0x80000000 gives 0x80000000.
- FSM states: IDLE, LAUNCH, WAIT, FIX, DONE, ZERO.
- IDLE:
  - start & rt==0 -> ZERO.
  - start & rt!=0 -> LAUNCH.
  - Otherwise stay in IDLE.
- ZERO:
  - done=1 and div0_exc=1 for exactly this one cycle; HI/LO unchanged; divider never launched.
  - Next state IDLE.
- LAUNCH:
  - div_init=1 for exactly this cycle; div_a/div_b already hold ma/mb.
  - counter<=LATENCY-1; next state WAIT.
- WAIT: counter decrements each cycle; at counter==0 -> FIX. The state lasts exactly LATENCY cycles.
- FIX: at the end of the cycle capture:
  - lo_out <= sign_q ? -div_lo : div_lo
  - hi_out <= sign_r ? -div_hi : div_hi
  - next state DONE
- DONE: done=1 for one cycle; new HI/LO already visible; next state IDLE.
- Latency: start sampled at edge 0 -> done high in cycle LATENCY+3. Divide-by-zero -> done in cycle 1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: result lo=0x80000000, hi=0; no exception.
- start while busy: ignored, no queueing.
- abort in any non-IDLE state:
  - Next cycle div_stop=1 for one cycle, state=IDLE.
  - HI/LO unchanged, no done, no div0_exc.
  - abort takes priority over FIX capture in the same cycle.
  - abort in IDLE has no effect.
- hi_we/lo_we:
  - Honoured only in IDLE without start.
  - Write hi_out/lo_out at the edge.
  - hi_we and lo_we may both be high; each register gets wdata.
  - If start and a write coincide in IDLE, start wins and the write is dropped.
  - Ignored while busy.
- All arithmetic is 32-bit modulo; no carries are kept.

Optional Feature:
- Macro DIV_SEQ_SMALL_BYPASS_EN.
- Defined: in IDLE, start with rt!=0 and ma<mb goes IDLE -> FIX.
  - In FIX: lo_out<=0 and hi_out<=rs (the original signed value); divider not launched, no div_init.
  - done appears in cycle 2.
- Undefined: every nonzero-divisor operation takes the full LAUNCH/WAIT path.
- Remaining behaviour is identical in both builds.

Test Plan:
- Bench divider model: returns unsigned quotient on div_lo and remainder on div_hi, LATENCY cycles after div_init.
- Scenarios:
  - DIVU rs=100 rt=7 -> div_init one pulse; done in cycle 37; lo_out=14, hi_out=2; busy low after done.
  - DIV rs=-7 (0xFFFFFFF9), rt=2 -> div_a=7, div_b=2; lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
  - DIV rs=0x80000000, rt=0xFFFFFFFF -> div_a=0x80000000, div_b=1; lo_out=0x80000000, hi_out=0.
  - Divide-by-zero: preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIVU rs=5 rt=0 -> done and div0_exc high in cycle 1; HI/LO stay 0x11/0x22; div_init never asserted.
  - Abort at WAIT cycle 10 -> div_stop pulse next cycle; busy low; no done; HI/LO unchanged; a second start issued while busy earlier is ignored.
  - Async rst asserted mid-WAIT, between clock edges -> all outputs 0 immediately.
    - With DIV_SEQ_SMALL_BYPASS_EN: DIVU 3/9 -> done in cycle 2, lo_out=0, hi_out=3, no div_init.
